base2_pow2_pipe: RTL

//  Multi-lane, pipelined power-of-two quantiser for the approximate (log-domain) multiplier datapath.

---
 rtl/base2_pow2_pipe_if.sv | 28 ++
 rtl/base2_pow2_pipe.sv | 126 ++++++++++++
 2 files changed

// File: rtl/base2_pow2_pipe_if.sv
// Stream bundle for the power-of-two quantiser: operand vector in, (K, 2**K, flags) vector out.
// "slave" is the quantiser's view of the bundle; "master" is the producer/consumer side.
interface base2_pow2_pipe_if #(
  parameter int WIDTH      = 16,
  parameter int LOG2_WIDTH = 4,
  parameter int LANES      = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic                        in_mode;
  logic [LANES*WIDTH-1:0]      in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*LOG2_WIDTH-1:0] out_k;
  logic [LANES*WIDTH-1:0]      out_pow2;
  logic [LANES-1:0]            out_zero;
  logic [LANES-1:0]            out_sat;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_k, out_pow2, out_zero, out_sat
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_k, out_pow2, out_zero, out_sat
  );
endinterface

// File: rtl/base2_pow2_pipe.sv
// Multi-lane leading-one quantiser: S1 finds K and the bit below it, S2 floors or rounds
// to a power of two with saturation at 2**(WIDTH-1). Two-stage elastic pipeline.
module base2_pow2_pipe #(
  parameter int WIDTH      = 16,
  parameter int LOG2_WIDTH = 4,
  parameter int LANES      = 4
) (
  input  logic               clk,
  input  logic               rst,
  base2_pow2_pipe_if.slave   bus
);

  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic s1_mode_d, s1_mode_q;
  logic s1_load, s2_load;
  logic s1_en, s2_en;

  // A stage may take new data when empty or when its contents move on this cycle.
  always_comb begin
    s2_load    = !s2_valid_q || bus.out_ready;
    s1_load    = !s1_valid_q || s2_load;
    s1_en      = s1_load && bus.in_valid;
    s2_en      = s2_load && s1_valid_q;
    s1_valid_d = s1_load ? bus.in_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s1_mode_d  = s1_en ? bus.in_mode : s1_mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_mode_q  <= s1_mode_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [WIDTH-1:0]      op;
    logic [LOG2_WIDTH-1:0] s1_k_d, s1_k_q;
    logic                  s1_zero_d, s1_zero_q;
    logic                  s1_rbit_d, s1_rbit_q;
    logic [LOG2_WIDTH:0]   kr;
    logic [LOG2_WIDTH-1:0] out_k_d, out_k_q;
    logic [WIDTH-1:0]      out_pow2_d, out_pow2_q;
    logic                  out_zero_d, out_zero_q;
    logic                  out_sat_d, out_sat_q;

    assign op = bus.in_data[gi*WIDTH +: WIDTH];

    always_comb begin
      s1_k_d    = s1_k_q;
      s1_zero_d = s1_zero_q;
      s1_rbit_d = s1_rbit_q;
      if (s1_en) begin
        s1_k_d    = '0;
        s1_rbit_d = 1'b0;
        s1_zero_d = (op == '0);
        // Ascending scan: the last set bit seen is the leading one.
        for (int i = 1; i < WIDTH; i++) begin
          if (op[i]) begin
            s1_k_d    = LOG2_WIDTH'(i);
            s1_rbit_d = op[i-1];
          end
        end
      end
    end

    // Kr is one bit wider than K so that K = WIDTH-1 plus a round bit is seen as overflow.
    always_comb begin
      kr         = {1'b0, s1_k_q} + {{LOG2_WIDTH{1'b0}}, s1_mode_q & s1_rbit_q};
      out_k_d    = out_k_q;
      out_pow2_d = out_pow2_q;
      out_zero_d = out_zero_q;
      out_sat_d  = out_sat_q;
      if (s2_en) begin
        out_zero_d = s1_zero_q;
        out_sat_d  = 1'b0;
        if (s1_zero_q) begin
          out_k_d    = '0;
          out_pow2_d = '0;
        end else if (kr == (LOG2_WIDTH+1)'(WIDTH)) begin
          out_k_d    = LOG2_WIDTH'(WIDTH-1);
          out_pow2_d = WIDTH'(1) << (WIDTH-1);
          out_sat_d  = 1'b1;
        end else begin
          out_k_d    = kr[LOG2_WIDTH-1:0];
          out_pow2_d = WIDTH'(1) << kr;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_k_q     <= '0;
        s1_zero_q  <= 1'b0;
        s1_rbit_q  <= 1'b0;
        out_k_q    <= '0;
        out_pow2_q <= '0;
        out_zero_q <= 1'b0;
        out_sat_q  <= 1'b0;
      end else begin
        s1_k_q     <= s1_k_d;
        s1_zero_q  <= s1_zero_d;
        s1_rbit_q  <= s1_rbit_d;
        out_k_q    <= out_k_d;
        out_pow2_q <= out_pow2_d;
        out_zero_q <= out_zero_d;
        out_sat_q  <= out_sat_d;
      end
    end

    assign bus.out_k[gi*LOG2_WIDTH +: LOG2_WIDTH] = out_k_q;
    assign bus.out_pow2[gi*WIDTH +: WIDTH]        = out_pow2_q;
    assign bus.out_zero[gi]                       = out_zero_q;
    assign bus.out_sat[gi]                        = out_sat_q;
  end

endmodule
